// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's single write port between the ALU writeback
// source (A) and the memory-load writeback source (M). Each source uses a
// valid/ready handshake. At most one request is granted per cycle, and a
// simultaneous request from both sources is resolved round-robin. The
// register-file write port is driven from registered outputs. A saturating
// counter records contention cycles for performance debug.
//
// Ports
//   Clk            clock, rising edge
//   Reset          synchronous, active-high
//   Hold           blocks all grants while high
//   ValidA/RegA/DataA, ReadyA   ALU writeback request and its grant
//   ValidM/RegM/DataM, ReadyM   load writeback request and its grant
//   RegWrite/WriteRegister/WriteData   registered register-file write port
//   LastGrantM     1 when the most recent grant went to M
//   ConflictCount  saturating count of cycles where both were valid and Hold was low
module regfile_write_arbiter #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Hold,
  input  logic                   ValidA,
  input  logic [4:0]             RegA,
  input  logic [31:0]            DataA,
  output logic                   ReadyA,
  input  logic                   ValidM,
  input  logic [4:0]             RegM,
  input  logic [31:0]            DataM,
  output logic                   ReadyM,
  output logic                   RegWrite,
  output logic [4:0]             WriteRegister,
  output logic [31:0]            WriteData,
  output logic                   LastGrantM,
  output logic [COUNT_WIDTH-1:0] ConflictCount
);

  logic                   vld_p1;
  logic [4:0]             writeRegister_p1;
  logic [31:0]            writeData_p1;
  logic                   lastGrantM_p1;
  logic [COUNT_WIDTH-1:0] conflictCount_p1;
  logic                   conflict;

  function automatic logic [COUNT_WIDTH-1:0] satInc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  // Stage 0: combinational grant. A lone requester always wins while Hold is
  // low. On a tie, the grant goes to the source that did not win last time.
  assign ReadyA   = ~Reset & ~Hold & ValidA & (~ValidM | lastGrantM_p1);
  assign ReadyM   = ~Reset & ~Hold & ValidM & (~ValidA | ~lastGrantM_p1);
  assign conflict = ValidA & ValidM & ~Hold;

  // Stage 1: registered write port, round-robin state and contention counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1           <= 1'b0;
      writeRegister_p1 <= '0;
      writeData_p1     <= '0;
      lastGrantM_p1    <= 1'b1;
      conflictCount_p1 <= '0;
    end else begin
      vld_p1 <= ReadyA | ReadyM;
      if (ReadyA) begin
        writeRegister_p1 <= RegA;
        writeData_p1     <= DataA;
        lastGrantM_p1    <= 1'b0;
      end else if (ReadyM) begin
        writeRegister_p1 <= RegM;
        writeData_p1     <= DataM;
        lastGrantM_p1    <= 1'b1;
      end
      if (conflict) begin
        conflictCount_p1 <= satInc(conflictCount_p1);
      end
    end
  end

  assign RegWrite      = vld_p1;
  assign WriteRegister = writeRegister_p1;
  assign WriteData     = writeData_p1;
  assign LastGrantM    = lastGrantM_p1;
  assign ConflictCount = conflictCount_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        Clk;
  logic        Reset, Hold;
  logic        ValidA, ValidM;
  logic [4:0]  RegA, RegM;
  logic [31:0] DataA, DataM;
  logic        ReadyA, ReadyM, RegWrite, LastGrantM;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [7:0]  ConflictCount;
  logic        satReadyA, satReadyM, satRegWrite, satLastGrantM;
  logic [4:0]  satWriteRegister;
  logic [31:0] satWriteData;
  logic [2:0]  satConflictCount;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.COUNT_WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Hold(Hold),
    .ValidA(ValidA), .RegA(RegA), .DataA(DataA), .ReadyA(ReadyA),
    .ValidM(ValidM), .RegM(RegM), .DataM(DataM), .ReadyM(ReadyM),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .LastGrantM(LastGrantM), .ConflictCount(ConflictCount)
  );

  regfile_write_arbiter #(.COUNT_WIDTH(3)) dutSat (
    .Clk(Clk), .Reset(Reset), .Hold(Hold),
    .ValidA(ValidA), .RegA(RegA), .DataA(DataA), .ReadyA(satReadyA),
    .ValidM(ValidM), .RegM(RegM), .DataM(DataM), .ReadyM(satReadyM),
    .RegWrite(satRegWrite), .WriteRegister(satWriteRegister), .WriteData(satWriteData),
    .LastGrantM(satLastGrantM), .ConflictCount(satConflictCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file that writes on the edge after RegWrite is presented.
  logic [31:0] rf [32];
  always @(posedge Clk) if (RegWrite) rf[WriteRegister] <= WriteData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic hold,
                       input logic vA, input logic [4:0] rA, input logic [31:0] dA,
                       input logic vM, input logic [4:0] rM, input logic [31:0] dM);
    Reset = rst; Hold = hold;
    ValidA = vA; RegA = rA; DataA = dA;
    ValidM = vM; RegM = rM; DataM = dM;
  endtask

  typedef struct {
    logic        rst, hold, vA;
    logic [4:0]  rA;
    logic [31:0] dA;
    logic        vM;
    logic [4:0]  rM;
    logic [31:0] dM;
    logic        eRA, eRM, eWe;
    logic [4:0]  eReg;
    logic [31:0] eData;
    logic        eLast;
    int          eCnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic hold, logic vA, logic [4:0] rA, logic [31:0] dA,
                              logic vM, logic [4:0] rM, logic [31:0] dM,
                              logic eRA, logic eRM, logic eWe, logic [4:0] eReg,
                              logic [31:0] eData, logic eLast, int eCnt);
    vec_t v;
    v.rst = rst; v.hold = hold; v.vA = vA; v.rA = rA; v.dA = dA;
    v.vM = vM; v.rM = rM; v.dM = dM; v.eRA = eRA; v.eRM = eRM; v.eWe = eWe;
    v.eReg = eReg; v.eData = eData; v.eLast = eLast; v.eCnt = eCnt;
    return v;
  endfunction

  vec_t tbl [23];

  // Behavioural reference for the randomized phase.
  logic        mWe, mLast;
  logic [4:0]  mReg;
  logic [31:0] mData;
  int          mCnt;

  function automatic int satTo(int v, int maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    //            rst hold vA rA  dA            vM rM dM     RA RM We reg dat           last cnt
    tbl[0]  = mk(1, 0, 1, 1, 32'h11,        1, 2, 32'h22, 0, 0, 0, 0, 32'h0,        1, 0);
    tbl[1]  = mk(1, 0, 1, 1, 32'h11,        1, 2, 32'h22, 0, 0, 0, 0, 32'h0,        1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 0, 32'h0,        1, 0);
    tbl[3]  = mk(0, 0, 1, 5, 32'hDEADBEEF,  0, 0, 32'h0,  1, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 5, 32'hDEADBEEF, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 0, 32'h0,        1, 0);
    tbl[6]  = mk(0, 0, 1, 1, 32'h11,        1, 2, 32'h22, 1, 0, 1, 1, 32'h11,       0, 1);
    tbl[7]  = mk(0, 0, 1, 1, 32'h11,        1, 2, 32'h22, 0, 1, 1, 2, 32'h22,       1, 2);
    tbl[8]  = mk(0, 0, 1, 1, 32'h11,        1, 2, 32'h22, 1, 0, 1, 1, 32'h11,       0, 3);
    tbl[9]  = mk(0, 0, 1, 1, 32'h11,        1, 2, 32'h22, 0, 1, 1, 2, 32'h22,       1, 4);
    tbl[10] = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 2, 32'h22,       1, 4);
    tbl[11] = mk(0, 0, 1, 7, 32'hA,         1, 7, 32'hB,  1, 0, 1, 7, 32'hA,        0, 5);
    tbl[12] = mk(0, 0, 0, 0, 32'h0,         1, 7, 32'hB,  0, 1, 1, 7, 32'hB,        1, 5);
    tbl[13] = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 7, 32'hB,        1, 5);
    tbl[14] = mk(0, 1, 1, 3, 32'h33,        1, 4, 32'h44, 0, 0, 0, 7, 32'hB,        1, 5);
    tbl[15] = mk(0, 1, 1, 3, 32'h33,        1, 4, 32'h44, 0, 0, 0, 7, 32'hB,        1, 5);
    tbl[16] = mk(0, 1, 1, 3, 32'h33,        1, 4, 32'h44, 0, 0, 0, 7, 32'hB,        1, 5);
    tbl[17] = mk(0, 0, 1, 3, 32'h33,        1, 4, 32'h44, 1, 0, 1, 3, 32'h33,       0, 6);
    tbl[18] = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 3, 32'h33,       0, 6);
    tbl[19] = mk(0, 0, 0, 0, 32'h0,         1, 0, 32'h55, 0, 1, 1, 0, 32'h55,       1, 6);
    tbl[20] = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 0, 32'h55,       1, 6);
    tbl[21] = mk(0, 0, 1, 9, 32'h99,        0, 0, 32'h0,  1, 0, 1, 9, 32'h99,       0, 6);
    tbl[22] = mk(1, 0, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0, 0, 0, 32'h0,        1, 0);

    @(posedge Clk); #1;

    // Table-driven directed vectors.
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst, tbl[i].hold, tbl[i].vA, tbl[i].rA, tbl[i].dA,
            tbl[i].vM, tbl[i].rM, tbl[i].dM);
      #1;
      chk($sformatf("tbl%0d ReadyA", i), {31'b0, ReadyA}, {31'b0, tbl[i].eRA});
      chk($sformatf("tbl%0d ReadyM", i), {31'b0, ReadyM}, {31'b0, tbl[i].eRM});
      @(posedge Clk); #1;
      chk($sformatf("tbl%0d RegWrite", i), {31'b0, RegWrite}, {31'b0, tbl[i].eWe});
      chk($sformatf("tbl%0d WriteRegister", i), {27'b0, WriteRegister}, {27'b0, tbl[i].eReg});
      chk($sformatf("tbl%0d WriteData", i), WriteData, tbl[i].eData);
      chk($sformatf("tbl%0d LastGrantM", i), {31'b0, LastGrantM}, {31'b0, tbl[i].eLast});
      chk($sformatf("tbl%0d ConflictCount", i), {24'b0, ConflictCount}, tbl[i].eCnt);
    end
    chk("collision r7 final", rf[7], 32'hB);

    // Saturation: both valid for 10 cycles after reset.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 1, 1, 32'h11, 1, 2, 32'h22);
      @(posedge Clk); #1;
      chk($sformatf("sat cycle%0d count3", i), {29'b0, satConflictCount}, satTo(i, 7));
      chk($sformatf("sat cycle%0d count8", i), {24'b0, ConflictCount}, i);
    end

    // Randomized phase against the reference model.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    mWe = 0; mReg = 0; mData = 0; mLast = 1; mCnt = 0;
    begin
      logic pA, pM, rst, hold;
      int   grant;
      pA = 0; pM = 0;
      for (int c = 0; c < 400; c++) begin
        if (!pA && $urandom_range(0, 2) != 0) begin
          pA = 1; RegA = 5'($urandom); DataA = $urandom;
        end
        if (!pM && $urandom_range(0, 2) != 0) begin
          pM = 1; RegM = 5'($urandom); DataM = $urandom;
        end
        rst  = ($urandom_range(0, 39) == 0);
        hold = ($urandom_range(0, 3) == 0);
        Reset = rst; Hold = hold; ValidA = pA; ValidM = pM;
        // 0 none, 1 A, 2 M
        if (rst || hold)      grant = 0;
        else if (pA && pM)    grant = mLast ? 1 : 2;
        else if (pA)          grant = 1;
        else if (pM)          grant = 2;
        else                  grant = 0;
        #1;
        chk($sformatf("rnd%0d ReadyA", c), {31'b0, ReadyA}, (grant == 1) ? 32'd1 : 32'd0);
        chk($sformatf("rnd%0d ReadyM", c), {31'b0, ReadyM}, (grant == 2) ? 32'd1 : 32'd0);
        if (rst) begin
          mWe = 0; mReg = 0; mData = 0; mLast = 1; mCnt = 0;
        end else begin
          mWe = (grant != 0);
          if (grant == 1) begin mReg = RegA; mData = DataA; mLast = 0; end
          if (grant == 2) begin mReg = RegM; mData = DataM; mLast = 1; end
          if (pA && pM && !hold) mCnt++;
        end
        @(posedge Clk); #1;
        if (grant == 1) pA = 0;
        if (grant == 2) pM = 0;
        chk($sformatf("rnd%0d RegWrite", c), {31'b0, RegWrite}, {31'b0, mWe});
        chk($sformatf("rnd%0d WriteRegister", c), {27'b0, WriteRegister}, {27'b0, mReg});
        chk($sformatf("rnd%0d WriteData", c), WriteData, mData);
        chk($sformatf("rnd%0d LastGrantM", c), {31'b0, LastGrantM}, {31'b0, mLast});
        chk($sformatf("rnd%0d ConflictCount", c), {24'b0, ConflictCount}, satTo(mCnt, 255));
        chk($sformatf("rnd%0d SatCount", c), {29'b0, satConflictCount}, satTo(mCnt, 7));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
